// File: rtl/core_trap_ctrl.sv
// Machine-mode trap controller: exception/MRET handling, trap CSRs and fetch redirect.
// Optional interrupt support is compiled in with `define CORE_TRAP_IRQ_EN.
module core_trap_ctrl #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exec_done,
    input  logic            ex_ecall,
    input  logic            ex_ebreak,
    input  logic            ex_exec_illegal_instr,
    input  logic            ex_instr_misaligned,
    input  logic            ex_load_misaligned,
    input  logic            ex_store_misaligned,
    input  logic            mret,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_next,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [31:0]     instr,
    input  logic [11:0]     csr_addr,
    input  logic            csr_wr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_hit,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
`ifdef CORE_TRAP_IRQ_EN
    input  logic            irq_m_ext,
    input  logic            irq_m_timer,
    input  logic            irq_m_soft,
`endif
    output logic            stall
);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    typedef enum logic {IDLE, REDIRECT} state_t;
    state_t state, state_nxt;

    logic [XLEN-1:2] mtvec_base;
    logic [XLEN-1:0] mepc, mcause, mtval;
    logic            st_mie, st_mpie;
    logic [XLEN-1:0] mtvec_rd;

    logic            exc_any;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_tval;
    logic            take_exc, take_irq, take_mret, take_trap;
    logic [XLEN-1:0] trap_target;

    always_comb begin
        exc_any  = ex_exec_illegal_instr | ex_instr_misaligned | ex_ebreak |
                   ex_ecall | ex_store_misaligned | ex_load_misaligned;
        exc_code = 4'd0;
        exc_tval = '0;
        if (ex_exec_illegal_instr) begin
            exc_code = 4'd2;  exc_tval = instr;
        end else if (ex_instr_misaligned) begin
            exc_code = 4'd0;  exc_tval = pc_next;
        end else if (ex_ebreak) begin
            exc_code = 4'd3;  exc_tval = pc;
        end else if (ex_ecall) begin
            exc_code = 4'd11; exc_tval = '0;
        end else if (ex_store_misaligned) begin
            exc_code = 4'd6;  exc_tval = mem_addr;
        end else if (ex_load_misaligned) begin
            exc_code = 4'd4;  exc_tval = mem_addr;
        end
    end

`ifdef CORE_TRAP_IRQ_EN
    logic       mtvec_mode;
    logic [2:0] mie_q;      // {ext, timer, soft}
    logic [2:0] irq_lines;
    logic [2:0] irq_pend;
    logic [3:0] irq_code;

    assign irq_lines = {irq_m_ext, irq_m_timer, irq_m_soft};
    assign irq_pend  = mie_q & irq_lines;
    assign irq_code  = irq_pend[2] ? 4'd11 : (irq_pend[0] ? 4'd3 : 4'd7);
    assign take_irq  = (state == IDLE) & exec_done & ~exc_any & st_mie & (|irq_pend);
    assign mtvec_rd  = {mtvec_base, 1'b0, mtvec_mode};
    // Vectored mode only offsets interrupts; exceptions always land on BASE.
    assign trap_target = (take_irq & mtvec_mode)
                       ? {mtvec_base, 2'b00} + {{(XLEN-6){1'b0}}, irq_code, 2'b00}
                       : {mtvec_base, 2'b00};
`else
    assign take_irq    = 1'b0;
    assign mtvec_rd    = {mtvec_base, 2'b00};
    assign trap_target = {mtvec_base, 2'b00};
`endif

    assign take_exc  = (state == IDLE) & exc_any;
    assign take_trap = take_exc | take_irq;
    assign take_mret = (state == IDLE) & exec_done & mret & ~exc_any & ~take_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (take_trap | take_mret) state_nxt = REDIRECT;
            REDIRECT: if (redirect_ready)        state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign redirect_valid = (state == REDIRECT);
    assign stall          = (state == REDIRECT);

    // CSR writes first; trap/MRET assignments below override them in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec_base  <= MTVEC_RESET[XLEN-1:2];
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
            st_mie      <= 1'b0;
            st_mpie     <= 1'b0;
            redirect_pc <= '0;
`ifdef CORE_TRAP_IRQ_EN
            mtvec_mode  <= (MTVEC_RESET[1:0] == 2'b01);
            mie_q       <= 3'b000;
`endif
        end else begin
            if (csr_wr) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        st_mie  <= csr_wdata[3];
                        st_mpie <= csr_wdata[7];
                    end
                    A_MTVEC: begin
                        mtvec_base <= csr_wdata[XLEN-1:2];
`ifdef CORE_TRAP_IRQ_EN
                        mtvec_mode <= (csr_wdata[1:0] == 2'b01);
`endif
                    end
                    A_MEPC:   mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
                    A_MCAUSE: mcause <= csr_wdata;
                    A_MTVAL:  mtval  <= csr_wdata;
`ifdef CORE_TRAP_IRQ_EN
                    A_MIE:    mie_q  <= {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
`endif
                    default: ;
                endcase
            end
            if (take_trap) begin
                st_mpie     <= st_mie;
                st_mie      <= 1'b0;
                redirect_pc <= trap_target;
`ifdef CORE_TRAP_IRQ_EN
                if (take_irq) begin
                    mepc   <= {pc_next[XLEN-1:2], 2'b00};
                    mcause <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                    mtval  <= '0;
                end else
`endif
                begin
                    mepc   <= {pc[XLEN-1:2], 2'b00};
                    mcause <= {{(XLEN-4){1'b0}}, exc_code};
                    mtval  <= exc_tval;
                end
            end else if (take_mret) begin
                st_mie      <= st_mpie;
                st_mpie     <= 1'b1;
                redirect_pc <= mepc;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        csr_hit   = 1'b1;
        case (csr_addr)
            A_MSTATUS: csr_rdata = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
            A_MTVEC:   csr_rdata = mtvec_rd;
            A_MEPC:    csr_rdata = mepc;
            A_MCAUSE:  csr_rdata = mcause;
            A_MTVAL:   csr_rdata = mtval;
`ifdef CORE_TRAP_IRQ_EN
            A_MIE:     csr_rdata = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
            A_MIP:     csr_rdata = {20'b0, irq_lines[2], 3'b0, irq_lines[1], 3'b0, irq_lines[0], 3'b0};
`endif
            default:   csr_hit   = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_core_trap_ctrl.sv
// Randomized bench for core_trap_ctrl against a CSR-level reference model.
module tb_core_trap_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        exec_done = 0, ex_ecall = 0, ex_ebreak = 0, ex_exec_illegal_instr = 0;
    logic        ex_instr_misaligned = 0, ex_load_misaligned = 0, ex_store_misaligned = 0;
    logic        mret = 0, csr_wr = 0, redirect_ready = 0;
    logic [31:0] pc = 0, pc_next = 0, mem_addr = 0, instr = 0, csr_wdata = 0;
    logic [11:0] csr_addr = 0;
    logic [31:0] csr_rdata, redirect_pc;
    logic        csr_hit, redirect_valid, stall;
`ifdef CORE_TRAP_IRQ_EN
    logic        irq_m_ext = 0, irq_m_timer = 0, irq_m_soft = 0;
`endif

    core_trap_ctrl #(.XLEN(32), .MTVEC_RESET(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .exec_done(exec_done),
        .ex_ecall(ex_ecall), .ex_ebreak(ex_ebreak),
        .ex_exec_illegal_instr(ex_exec_illegal_instr),
        .ex_instr_misaligned(ex_instr_misaligned),
        .ex_load_misaligned(ex_load_misaligned),
        .ex_store_misaligned(ex_store_misaligned),
        .mret(mret), .pc(pc), .pc_next(pc_next), .mem_addr(mem_addr), .instr(instr),
        .csr_addr(csr_addr), .csr_wr(csr_wr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_hit(csr_hit),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready),
`ifdef CORE_TRAP_IRQ_EN
        .irq_m_ext(irq_m_ext), .irq_m_timer(irq_m_timer), .irq_m_soft(irq_m_soft),
`endif
        .stall(stall)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        m_mie, m_mpie;

    task automatic model_reset();
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mie = 0; m_mpie = 0;
    endtask

    function automatic logic [31:0] m_mstatus();
        return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
`ifdef CORE_TRAP_IRQ_EN
            12'h305: m_mtvec = {d[31:2], 1'b0, (d[1:0] == 2'b01)};
`else
            12'h305: m_mtvec = {d[31:2], 2'b00};
`endif
            12'h341: m_mepc = d & 32'hFFFF_FFFC;
            12'h342: m_mcause = d;
            12'h343: m_mtval = d;
            default: ;
        endcase
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic check_csrs(input string tag);
        logic [31:0] d;
        rd(12'h300, d); chk({tag, ":mstatus"}, d, m_mstatus());
        rd(12'h305, d); chk({tag, ":mtvec"}, d, m_mtvec);
        rd(12'h341, d); chk({tag, ":mepc"}, d, m_mepc);
        rd(12'h342, d); chk({tag, ":mcause"}, d, m_mcause);
        rd(12'h343, d); chk({tag, ":mtval"}, d, m_mtval);
        @(negedge clk);
    endtask

    // fl = {illegal, instr_mis, ebreak, ecall, store_mis, load_mis}; called at a negedge.
    task automatic step(input logic ed, input logic [5:0] fl, input logic mr,
                        input logic [31:0] p, input logic [31:0] pn, input logic [31:0] ma,
                        input logic [31:0] ins, input logic wr, input logic [11:0] wa,
                        input logic [31:0] wd, input int hold, input string tag);
        int          codes [6];
        logic [31:0] old_mtvec, old_mepc, tgt, tval;
        logic        old_mie, old_mpie, redir;
        int          sel;
        codes = '{2, 0, 3, 11, 6, 4};
        exec_done = ed; mret = mr; pc = p; pc_next = pn; mem_addr = ma; instr = ins;
        {ex_exec_illegal_instr, ex_instr_misaligned, ex_ebreak, ex_ecall,
         ex_store_misaligned, ex_load_misaligned} = fl;
        csr_wr = wr; csr_addr = wa; csr_wdata = wd;

        old_mtvec = m_mtvec; old_mepc = m_mepc; old_mie = m_mie; old_mpie = m_mpie;
        redir = 0; tgt = 0; sel = -1;
        if (wr) model_write(wa, wd);
        for (int k = 5; k >= 0; k--) if (fl[k] && sel < 0) sel = 5 - k;
        if (sel >= 0) begin
            case (sel)
                0:       tval = ins;
                1:       tval = pn;
                2:       tval = p;
                3:       tval = 0;
                default: tval = ma;
            endcase
            m_mepc = p & 32'hFFFF_FFFC; m_mcause = codes[sel]; m_mtval = tval;
            m_mpie = old_mie; m_mie = 0;
            tgt = {old_mtvec[31:2], 2'b00}; redir = 1;
        end else if (ed && mr) begin
            m_mie = old_mpie; m_mpie = 1;
            tgt = old_mepc; redir = 1;
        end

        @(negedge clk);
        exec_done = 0; mret = 0; csr_wr = 0;
        {ex_exec_illegal_instr, ex_instr_misaligned, ex_ebreak, ex_ecall,
         ex_store_misaligned, ex_load_misaligned} = 6'b0;
        if (redir) begin
            chk({tag, ":valid"}, 32'(redirect_valid), 32'd1);
            chk({tag, ":stall"}, 32'(stall), 32'd1);
            chk({tag, ":rpc"}, redirect_pc, tgt);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, ":hold_valid"}, 32'(redirect_valid), 32'd1);
                chk({tag, ":hold_stall"}, 32'(stall), 32'd1);
                chk({tag, ":hold_rpc"}, redirect_pc, tgt);
            end
            redirect_ready = 1;
            @(negedge clk);
            redirect_ready = 0;
            chk({tag, ":released"}, 32'(redirect_valid), 32'd0);
            chk({tag, ":unstall"}, 32'(stall), 32'd0);
        end else begin
            chk({tag, ":no_redirect"}, 32'(redirect_valid), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout reached, simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [11:0] addrs [5];
        addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343};
        model_reset();

        #3;
        chk("rst:valid", 32'(redirect_valid), 32'd0);
        chk("rst:stall", 32'(stall), 32'd0);
        chk("rst:rpc", redirect_pc, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        check_csrs("rst");
        rd(12'h7C0, d); chk("unowned:rdata", d, 32'd0);
        chk("unowned:hit", 32'(csr_hit), 32'd0);
        rd(12'h341, d); chk("owned:hit", 32'(csr_hit), 32'd1);
        @(negedge clk);

        // ecall at pc 0x100 with mtvec 0x800 and MIE=1
        step(0, 6'b0, 0, 0, 0, 0, 0, 1, 12'h305, 32'h800, 0, "wr_mtvec");
        step(0, 6'b0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h8, 0, "wr_mstatus");
        step(1, 6'b000100, 0, 32'h100, 32'h104, 32'h0, 32'h0, 0, 0, 0, 0, "ecall");
        chk("ecall:rpc_const", redirect_pc, 32'h800);
        rd(12'h341, d); chk("ecall:mepc", d, 32'h100);
        rd(12'h342, d); chk("ecall:mcause", d, 32'd11);
        rd(12'h343, d); chk("ecall:mtval", d, 32'd0);
        rd(12'h300, d); chk("ecall:mstatus", d, 32'h1880);
        check_csrs("ecall");

        // illegal + load misaligned together, held for 3 cycles
        step(1, 6'b100001, 0, 32'h200, 32'h204, 32'h33, 32'hFFFF_FFFF, 0, 0, 0, 3, "illegal");
        rd(12'h342, d); chk("illegal:mcause", d, 32'd2);
        rd(12'h343, d); chk("illegal:mtval", d, 32'hFFFF_FFFF);
        check_csrs("illegal");

        // MRET back to 0x204 with MPIE=1
        step(0, 6'b0, 0, 0, 0, 0, 0, 1, 12'h341, 32'h204, 0, "wr_mepc");
        step(0, 6'b0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h80, 0, "wr_mpie");
        step(1, 6'b0, 1, 32'h500, 32'h504, 0, 0, 0, 0, 0, 1, "mret");
        rd(12'h300, d); chk("mret:mstatus", d, 32'h1888);
        check_csrs("mret");

        // trap beats same-cycle mepc write
        step(1, 6'b000010, 0, 32'h300, 32'h304, 32'h1001, 0, 1, 12'h341, 32'h40, 0, "st_mis");
        rd(12'h341, d); chk("st_mis:mepc", d, 32'h300);
        rd(12'h342, d); chk("st_mis:mcause", d, 32'd6);
        rd(12'h343, d); chk("st_mis:mtval", d, 32'h1001);
        check_csrs("st_mis");

        // same-cycle mtvec write: trap uses the old vector
        step(1, 6'b001000, 0, 32'h600, 32'h604, 0, 0, 1, 12'h305, 32'h900, 0, "mtvec_race");
        rd(12'h305, d); chk("mtvec_race:mtvec", d, 32'h900);
        check_csrs("mtvec_race");

`ifdef CORE_TRAP_IRQ_EN
        step(0, 6'b0, 0, 0, 0, 0, 0, 1, 12'h305, 32'h801, 0, "irq_mtvec");
        step(0, 6'b0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h8, 0, "irq_mstatus");
        step(0, 6'b0, 0, 0, 0, 0, 0, 1, 12'h304, 32'h80, 0, "irq_mie");
        irq_m_timer = 1;
        rd(12'h344, d); chk("irq:mip", d, 32'h80);
        exec_done = 1; pc = 32'h40; pc_next = 32'h44;
        @(negedge clk);
        exec_done = 0; irq_m_timer = 0;
        chk("irq:valid", 32'(redirect_valid), 32'd1);
        chk("irq:rpc", redirect_pc, 32'h81C);
        redirect_ready = 1;
        @(negedge clk);
        redirect_ready = 0;
        rd(12'h342, d); chk("irq:mcause", d, 32'h8000_0007);
        rd(12'h341, d); chk("irq:mepc", d, 32'h44);
        m_mepc = 32'h44; m_mcause = 32'h8000_0007; m_mtval = 0; m_mpie = 1; m_mie = 0;
        check_csrs("irq");
`endif

        for (int it = 0; it < 150; it++) begin
            logic [5:0]  fl;
            logic        ed, mr, wr;
            int          r;
            r  = $urandom_range(0, 9);
            fl = 6'b0;
            if (r >= 4)
                for (int b = 0; b < 6; b++) fl[b] = ($urandom_range(0, 4) == 0);
            ed = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 2) == 0);
            step(ed, fl, mr, $urandom, $urandom, $urandom, $urandom, wr,
                 addrs[$urandom_range(0, 4)], $urandom, $urandom_range(0, 3), "rand");
            check_csrs("rand");
        end

        // reset while a redirect is pending drops it immediately
        exec_done = 1; ex_ebreak = 1; pc = 32'h700;
        @(negedge clk);
        exec_done = 0; ex_ebreak = 0;
        chk("rst_redir:valid_before", 32'(redirect_valid), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_redir:valid", 32'(redirect_valid), 32'd0);
        chk("rst_redir:stall", 32'(stall), 32'd0);
        chk("rst_redir:rpc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        check_csrs("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/core_trap_ctrl.md
# core_trap_ctrl

Machine-mode trap controller, directly downstream of the execute-stage exception detector. Consumes the per-instruction exception flags and `mret`, selects the highest-priority cause, and updates `mepc`/`mcause`/`mtval`/`mstatus`. Issues a held redirect to the fetch stage (trap vector or `mepc`) and stalls the core until fetch accepts it. Owns the trap CSRs and their read/write port.

## Interface
- `XLEN`, 32: data/address width (only 32 supported).
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec`.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `exec_done`  in  1  instruction retires this cycle
- `ex_ecall`, `ex_ebreak`, `ex_exec_illegal_instr`, `ex_instr_misaligned`, `ex_load_misaligned`, `ex_store_misaligned`  in  1 each  exception flags, already qualified by the detector
- `mret`  in  1  retiring instruction is MRET (qualified with `exec_done` internally)
- `pc`  in  XLEN  PC of the retiring instruction
- `pc_next`  in  XLEN  PC of the following instruction (jump target or `pc+4`)
- `mem_addr`  in  XLEN  effective load/store address
- `instr`  in  32  raw instruction bits
- `csr_addr`  in  12  CSR address
- `csr_wr`  in  1  CSR write strobe
- `csr_wdata`  in  XLEN  CSR write data
- `csr_rdata`  out  XLEN  combinational read data; 0 for unowned addresses
- `csr_hit`  out  1  `csr_addr` is owned by this block
- `redirect_valid`  out  1  redirect request to fetch
- `redirect_pc`  out  XLEN  redirect target
- `redirect_ready`  in  1  fetch accepts the redirect
- `stall`  out  1  freeze the pipeline
- `irq_m_ext`, `irq_m_timer`, `irq_m_soft`  in  1 each  level interrupts (only with `CORE_TRAP_IRQ_EN`)

## Operation
- Owned CSRs:
  - `mstatus` 0x300: MIE bit 3, MPIE bit 7; MPP bits 12:11 read as 2'b11; all other bits read 0.
  - `mtvec` 0x305: BASE in bits 31:2, MODE in bits 1:0. MODE values other than 0/1 are written as 0.
  - `mepc` 0x341: bits 1:0 forced to 0.
  - `mcause` 0x342, `mtval` 0x343.
  - `mie` 0x304, `mip` 0x344: IRQ feature only.
- Exception priority, highest first; each row gives the mcause code and the mtval value:
  - illegal: 2, `instr`
  - instr misaligned: 0, `pc_next`
  - ebreak: 3, `pc`
  - ecall: 11, 0
  - store/AMO misaligned: 6, `mem_addr`
  - load misaligned: 4, `mem_addr`
- Trap entry (any flag set while in IDLE): `mepc<=pc`, `mcause<=code`, `mtval<=value`, `MPIE<=MIE`, `MIE<=0`, `redirect_pc<={mtvec[31:2],2'b00}`, go to REDIRECT.
- MRET (`exec_done & mret`, no exception): `MIE<=MPIE`, `MPIE<=1`, `redirect_pc<=mepc`, go to REDIRECT.
- FSM states:
  - IDLE: no redirect pending.
  - REDIRECT: `redirect_valid=1`; return to IDLE on the edge where `redirect_ready=1`.
- `stall = (state==REDIRECT)`.
- Inputs arriving while in REDIRECT are ignored; the stalled pipeline produces none.
- Simultaneous events:
  - An exception beats `mret`.
  - Trap or MRET updates beat a same-cycle `csr_wr` to `mstatus`/`mepc`/`mcause`/`mtval`.
  - A same-cycle `mtvec` write takes effect only after the current trap, which uses the old `mtvec`.

## Timing
- Detection is combinational in the `exec_done` cycle. CSRs and `redirect_pc` update at the next edge, and `redirect_valid` rises in the following cycle.
- The trap-to-redirect latency is therefore 1 cycle.
- `redirect_valid` and `redirect_pc` stay stable until accepted. Minimum REDIRECT residency is 1 cycle.
- CSR writes land at the edge; `csr_rdata` reflects the new value the following cycle.
- Reset values:
  - state IDLE; `redirect_valid` 0; `redirect_pc` 0; `stall` 0.
  - `mepc`, `mcause`, `mtval`, MIE, MPIE, `mie` all 0.
  - `mtvec` = `MTVEC_RESET`.
- Asserting `rst_n` low while in REDIRECT drops the request immediately.

## Configuration
- `CORE_TRAP_IRQ_EN` defined:
  - `irq_*` ports exist; `mip` bits 11/7/3 reflect ext/timer/soft, read-only; `mie` bits 11/7/3 are writable.
  - An interrupt is taken at an `exec_done` with no exception when `MIE & |(mie&mip)`.
  - Interrupt priority is ext > soft > timer. On entry `mepc<=pc_next`, `mcause<={1'b1,code}`, `mtval<=0`.
  - In vectored mode (MODE=1) the target is BASE+4*code.
  - An exception beats an interrupt.
- Undefined: no `irq_*` ports; `mie`/`mip` read 0 and writes are ignored; MODE is read-only 0.

## Test plan
- ecall at `pc`=0x100 with `mtvec`=0x800 -> one cycle later `redirect_valid`=1, `redirect_pc`=0x800, `mepc`=0x100, `mcause`=11, `mtval`=0, MIE=0, MPIE=old MIE.
- Illegal and load-misaligned asserted together, `instr`=0xFFFF_FFFF -> `mcause`=2, `mtval`=0xFFFF_FFFF.
- Hold `redirect_ready`=0 for 3 cycles -> `redirect_valid` and `stall` stay 1 with stable `redirect_pc`; IDLE one edge after `ready`=1.
- After a trap, MRET with `mepc`=0x204 -> `redirect_pc`=0x204, MIE restored, MPIE=1.
- Same-cycle `csr_wr` to `mepc` (0x40) and a store-misaligned trap at `pc`=0x300, `mem_addr`=0x1001 -> `mepc`=0x300, `mcause`=6, `mtval`=0x1001.
- With IRQ enabled: MIE=1, `mie[7]`=1, `irq_m_timer`=1, vectored `mtvec`=0x801, retire with `pc_next`=0x44 -> `redirect_pc`=0x81C, `mcause`=0x8000_0007, `mepc`=0x44.
